// File: rtl/vote_top.sv
// Nine-voter sticky majority judge: synchronised, latched votes drive LEDs,
// a pass/fail verdict and a scanned 4-digit 7-segment display.
module vote_top #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        LD10,
    input  logic [8:0]  vote,
    output logic [10:0] LD,
    output logic [3:0]  seg_light,
    output logic [7:0]  seg
);
    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    localparam logic [3:0] SYM_P     = 4'd10;
    localparam logic [3:0] SYM_F     = 4'd11;
    localparam logic [3:0] SYM_BLANK = 4'd15;

    logic [8:0]       s1_reg;
    logic [8:0]       s2_reg;
    logic [8:0]       latched_reg;
    logic [8:0]       latched_next;
    logic [DIV_W-1:0] div_reg;
    logic [1:0]       idx_reg;

    logic [3:0] yes_count;
    logic [3:0] no_count;
    logic       pass;
    logic [3:0] sym;

    // Running popcount: cnt[k] holds the number of yes votes among bits below k.
    logic [3:0] cnt [0:9];
    assign cnt[0] = 4'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_bit
            assign latched_next[gi] = latched_reg[gi] | s2_reg[gi];
            assign cnt[gi+1]        = cnt[gi] + {3'b000, latched_reg[gi]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (LD10) begin
            s1_reg      <= '0;
            s2_reg      <= '0;
            latched_reg <= '0;
            div_reg     <= '0;
            idx_reg     <= '0;
        end else begin
            s1_reg      <= vote;
            s2_reg      <= s1_reg;
            latched_reg <= latched_next;
            if (div_reg == DIV_LAST) begin
                div_reg <= '0;
                idx_reg <= idx_reg + 2'd1;
            end else begin
                div_reg <= div_reg + DIV_W'(1);
            end
        end
    end

    assign yes_count = cnt[9];
    assign no_count  = 4'd9 - yes_count;
    assign pass      = (yes_count >= 4'd5);
    assign LD        = {~pass, pass, latched_reg};

    always_comb begin
        seg_light = 4'b1110;
        sym       = SYM_BLANK;
        case (idx_reg)
            2'd0: begin seg_light = 4'b1110; sym = yes_count; end
            2'd1: begin seg_light = 4'b1101; sym = no_count; end
            2'd2: begin seg_light = 4'b1011; sym = SYM_BLANK; end
            2'd3: begin seg_light = 4'b0111; sym = pass ? SYM_P : SYM_F; end
            default: begin seg_light = 4'b1110; sym = SYM_BLANK; end
        endcase
    end

    always_comb begin
        seg = 8'hFF;
        case (sym)
            4'd0:  seg = 8'hC0;
            4'd1:  seg = 8'hF9;
            4'd2:  seg = 8'hA4;
            4'd3:  seg = 8'hB0;
            4'd4:  seg = 8'h99;
            4'd5:  seg = 8'h92;
            4'd6:  seg = 8'h82;
            4'd7:  seg = 8'hF8;
            4'd8:  seg = 8'h80;
            4'd9:  seg = 8'h90;
            SYM_P: seg = 8'h8C;
            SYM_F: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end
endmodule

// File: tb/tb_vote_top.sv
// Directed bench for vote_top with a short scan period so every digit slot is
// visited quickly; inputs change and outputs are sampled on the falling edge.
module tb_vote_top;
    logic        clk = 1'b0;
    logic        LD10 = 1'b1;
    logic [8:0]  vote = '0;
    logic [10:0] LD;
    logic [3:0]  seg_light;
    logic [7:0]  seg;

    int n_cmp = 0;
    int n_bad = 0;

    vote_top #(.SCAN_DIV(4)) dut (
        .clk(clk),
        .LD10(LD10),
        .vote(vote),
        .LD(LD),
        .seg_light(seg_light),
        .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        LD10 = 1'b1;
        edges(n);
        LD10 = 1'b0;
    endtask

    // Bounded wait for a given digit slot to become active.
    task automatic wait_slot(input logic [3:0] sl);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (seg_light == sl) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) check_val("slot_timeout", {28'd0, seg_light}, {28'd0, sl});
    endtask

    initial begin
        // Reset held with all switches high
        @(negedge clk);
        vote = 9'h1FF;
        LD10 = 1'b1;
        edges(2);
        check_val("rst_ld", {21'd0, LD}, 32'h400);
        check_val("rst_segl", {28'd0, seg_light}, 32'hE);
        check_val("rst_seg", {24'd0, seg}, 32'hC0);
        LD10 = 1'b0;
        edges(2);
        check_val("relatch_lat2", {21'd0, LD}, 32'h400);
        edges(1);
        check_val("relatch_lat3", {21'd0, LD}, 32'h3FF);
        wait_slot(4'b1110);
        check_val("all_yes_d0", {24'd0, seg}, 32'h90);
        wait_slot(4'b1101);
        check_val("all_yes_d1", {24'd0, seg}, 32'hC0);
        wait_slot(4'b0111);
        check_val("all_yes_d3", {24'd0, seg}, 32'h8C);

        // Clear mid-operation with switches low
        vote = 9'h000;
        edges(2);
        LD10 = 1'b1;
        edges(1);
        LD10 = 1'b0;
        check_val("clear_ld", {21'd0, LD}, 32'h400);
        wait_slot(4'b1110);
        check_val("clear_d0", {24'd0, seg}, 32'hC0);

        // Single vote, all four slots
        do_reset(2);
        vote = 9'h001;
        edges(3);
        check_val("single_ld", {21'd0, LD}, 32'h401);
        wait_slot(4'b1110);
        check_val("single_d0", {24'd0, seg}, 32'hF9);
        wait_slot(4'b1101);
        check_val("single_d1", {24'd0, seg}, 32'h80);
        wait_slot(4'b1011);
        check_val("single_d2", {24'd0, seg}, 32'hFF);
        wait_slot(4'b0111);
        check_val("single_d3", {24'd0, seg}, 32'h8E);

        // Threshold 4 -> fail, 5 -> pass
        do_reset(1);
        vote = 9'h00F;
        edges(3);
        check_val("thr4_ld", {21'd0, LD}, 32'h40F);
        check_val("thr4_verdict", {30'd0, LD[10:9]}, 32'h2);
        vote = 9'h01F;
        edges(3);
        check_val("thr5_verdict", {30'd0, LD[10:9]}, 32'h1);

        // Sticky: switches drop, latch holds
        vote = 9'h000;
        edges(6);
        check_val("sticky_ld", {21'd0, LD}, 32'h21F);
        wait_slot(4'b1110);
        check_val("sticky_d0", {24'd0, seg}, 32'h92);
        wait_slot(4'b1101);
        check_val("sticky_d1", {24'd0, seg}, 32'h99);
        wait_slot(4'b0111);
        check_val("sticky_d3", {24'd0, seg}, 32'h8C);

        // Scan rotation: each slot held exactly 4 cycles from reset release
        do_reset(1);
        check_val("scan_k0", {28'd0, seg_light}, 32'hE);
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] exp_sl;
            edges(1);
            case ((k / 4) % 4)
                0: exp_sl = 4'b1110;
                1: exp_sl = 4'b1101;
                2: exp_sl = 4'b1011;
                default: exp_sl = 4'b0111;
            endcase
            check_val($sformatf("scan_k%0d", k), {28'd0, seg_light}, {28'd0, exp_sl});
        end

        // Reset while idx=2
        do_reset(1);
        edges(9);
        check_val("scan_pre_rst", {28'd0, seg_light}, 32'hB);
        LD10 = 1'b1;
        edges(1);
        check_val("scan_rst_idx2", {28'd0, seg_light}, 32'hE);
        LD10 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
